// File: rtl/sobel_line_window.sv
// -----------------------------------------------------------------------------
// sobel_line_window
//
// Purpose:
//   Turns a raster-order pixel stream into 3x3 neighbourhood windows for the
//   Sobel gradient stage. The two previous image rows live in two internal
//   line memories (registered read, read-before-write on the same address).
//   Only fully populated windows are emitted: a window is produced for the
//   pixel at (row, col) only when row >= 2 and col >= 2. Its centre is the
//   pixel at (row-1, col-1).
//
// Ports:
//   clk_i      in   1            single clock
//   rst_i      in   1            asynchronous, active-high reset
//   valid_i    in   1            input pixel valid
//   ready_o    out  1            pixel accepted when valid_i && ready_o
//   data_i     in   WIDTH_P      input pixel, raster order
//   valid_o    out  1            window valid
//   ready_i    in   1            downstream ready
//   window_o   out  9*WIDTH_P    3x3 window; element k = r*3+c at
//                                [k*WIDTH_P +: WIDTH_P], r=0 oldest row,
//                                c=0 oldest column
//   sof_o      out  1            (SOBEL_LINE_WINDOW_TAGS_EN only) first window
//                                of a frame, centre at (1,1)
//   eol_o      out  1            (SOBEL_LINE_WINDOW_TAGS_EN only) last window
//                                of a row, centre column IMG_W_P-2
//
// Optional feature macro: SOBEL_LINE_WINDOW_TAGS_EN adds sof_o / eol_o.
//
// Handshake:
//   Both interfaces use valid/ready: a transfer happens on a rising clock edge
//   where valid and ready are both high. valid_o and window_o (and the tags)
//   hold steady while valid_o && !ready_i. The whole pipeline advances on
//   en = ready_i || !valid_o, and ready_o = en, so ready_o never depends on
//   valid_i.
// -----------------------------------------------------------------------------
module sobel_line_window #(
  parameter int WIDTH_P = 8,
  parameter int IMG_W_P = 640,
  parameter int IMG_H_P = 480
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic [WIDTH_P-1:0]     data_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [9*WIDTH_P-1:0]   window_o
`ifdef SOBEL_LINE_WINDOW_TAGS_EN
  ,
  output logic                   sof_o,
  output logic                   eol_o
`endif
);

  localparam int CW = (IMG_W_P > 2) ? $clog2(IMG_W_P) : 2;
  localparam int RW = (IMG_H_P > 2) ? $clog2(IMG_H_P) : 2;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W_P - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H_P - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  // ---------------------------------------------------------------------------
  // Pipeline enable and input handshake
  // ---------------------------------------------------------------------------
  logic en;
  logic accept;
  logic valid_o_q, valid_o_d;

  assign en      = ready_i || !valid_o_q;
  assign ready_o = en;
  assign accept  = valid_i && en;

  // ---------------------------------------------------------------------------
  // Raster position counters (position of the next pixel to be accepted)
  // ---------------------------------------------------------------------------
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: registered pixel with its raster position
  // ---------------------------------------------------------------------------
  logic               s1_v_q;
  logic [WIDTH_P-1:0] s1_pix_q;
  logic [CW-1:0]      s1_col_q;
  logic [RW-1:0]      s1_row_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_v_q   <= 1'b0;
      s1_pix_q <= '0;
      s1_col_q <= '0;
      s1_row_q <= '0;
    end else if (en) begin
      // A cycle with en but no accepted pixel moves a bubble into stage 1.
      s1_v_q <= valid_i;
      if (valid_i) begin
        s1_pix_q <= data_i;
        s1_col_q <= col_q;
        s1_row_q <= row_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line memories
  //   line0 holds the previous row, line1 the row before that. The read is
  //   registered and enabled by en, so the read data stays aligned with the
  //   stage-1 pixel through a stall. A read and a write to the same address in
  //   one cycle returns the old contents (the nonblocking write lands after
  //   the read has sampled). Contents are never reset; windows that would see
  //   unwritten entries are gated out by the row >= 2 condition.
  // ---------------------------------------------------------------------------
  logic [WIDTH_P-1:0] line0_mem [IMG_W_P];
  logic [WIDTH_P-1:0] line1_mem [IMG_W_P];
  logic [WIDTH_P-1:0] rd0_q;
  logic [WIDTH_P-1:0] rd1_q;
  logic               shift_en;

  assign shift_en = en && s1_v_q;

  always_ff @(posedge clk_i) begin
    if (en) begin
      rd0_q <= line0_mem[col_q];
      rd1_q <= line1_mem[col_q];
    end
    if (shift_en) begin
      line0_mem[s1_col_q] <= s1_pix_q;
      line1_mem[s1_col_q] <= rd0_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: three column-shift registers per window row
  //   Index 0 is the oldest column. Rows: top from line1, mid from line0,
  //   bottom from the live stage-1 pixel.
  // ---------------------------------------------------------------------------
  logic [2:0][WIDTH_P-1:0] top_q;
  logic [2:0][WIDTH_P-1:0] mid_q;
  logic [2:0][WIDTH_P-1:0] bot_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      top_q <= '0;
      mid_q <= '0;
      bot_q <= '0;
    end else if (shift_en) begin
      top_q <= {rd1_q,    top_q[2:1]};
      mid_q <= {rd0_q,    mid_q[2:1]};
      bot_q <= {s1_pix_q, bot_q[2:1]};
    end
  end

  // Window is complete only once two earlier rows and two earlier columns of
  // the current row have been shifted in. col >= 2 also keeps the columns
  // left over from the previous row out of any emitted window.
  always_comb begin
    valid_o_d = valid_o_q;
    if (en) begin
      valid_o_d = s1_v_q && (s1_row_q >= ROW_TWO) && (s1_col_q >= COL_TWO);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_o_q <= 1'b0;
    end else begin
      valid_o_q <= valid_o_d;
    end
  end

  assign valid_o  = valid_o_q;
  assign window_o = {bot_q, mid_q, top_q};

`ifdef SOBEL_LINE_WINDOW_TAGS_EN
  // ---------------------------------------------------------------------------
  // Frame / row tags, tracking the window they describe
  //   Window for pixel (2,2) is centred at (1,1): first window of the frame.
  //   Window for a pixel in the last column is the last window of its row.
  // ---------------------------------------------------------------------------
  logic sof_q, sof_d;
  logic eol_q, eol_d;

  always_comb begin
    sof_d = sof_q;
    eol_d = eol_q;
    if (en) begin
      sof_d = s1_v_q && (s1_row_q == ROW_TWO) && (s1_col_q == COL_TWO);
      eol_d = s1_v_q && (s1_row_q >= ROW_TWO) && (s1_col_q == COL_LAST);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sof_q <= 1'b0;
      eol_q <= 1'b0;
    end else begin
      sof_q <= sof_d;
      eol_q <= eol_d;
    end
  end

  assign sof_o = sof_q;
  assign eol_o = eol_q;
`endif

endmodule
